x_pulse_sequencer: RTL and testbench



---
 rtl/x_pulse_sequencer_pkg.sv | 16 +
 rtl/x_pulse_sequencer.sv | 132 +++++++++++++
 tb/tb_x_pulse_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/x_pulse_sequencer_pkg.sv
// Shared definitions for the X-pulse burst sequencer: FSM state encoding and
// default widths/modulus.
package x_pulse_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int CNT_W_DEFAULT = 8;
    localparam int GAP_W_DEFAULT = 4;
    localparam int MOD_DEFAULT   = 3;

endpackage

// File: rtl/x_pulse_sequencer.sv
// Emits bursts of single-cycle X pulses toward a mod-MOD detector and checks the
// detector's registered Z reply against an internal phase model.
module x_pulse_sequencer
    import x_pulse_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT,
    parameter int GAP_W = GAP_W_DEFAULT,
    parameter int MOD   = MOD_DEFAULT
) (
    input  logic             CLK_50M,
    input  logic             RST,
    input  logic             START,
    input  logic [CNT_W-1:0] PULSE_NUM,
    input  logic [GAP_W-1:0] GAP,
    input  logic             Z,
    output logic             X,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [CNT_W-1:0] Z_CNT
);

    localparam int PH_W = (MOD > 1) ? $clog2(MOD) : 1;

    state_t           state_q;
    logic [CNT_W-1:0] rem_q;
    logic [GAP_W-1:0] gap_lat_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [PH_W-1:0]  phase_q;
    logic             exp_z_q;
    logic             chk_q;
    logic             x_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [CNT_W-1:0] zcnt_q;

    logic [CNT_W-1:0] rem_d;
    logic             phase_last;
    logic             z_bad;

    assign rem_d      = rem_q - CNT_W'(1);
    assign phase_last = (phase_q == PH_W'(MOD - 1));
    // Only the cycle right after a pulse may legitimately carry Z=1.
    assign z_bad      = (Z != (chk_q && exp_z_q));

    always_ff @(posedge CLK_50M or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            gap_lat_q <= '0;
            gap_cnt_q <= '0;
            phase_q   <= '0;
            exp_z_q   <= 1'b0;
            chk_q     <= 1'b0;
            x_q       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            zcnt_q    <= '0;
        end else begin
            x_q    <= 1'b0;
            done_q <= 1'b0;
            chk_q  <= 1'b0;

            if (state_q != ST_IDLE) begin
                if (z_bad) begin
                    err_q <= 1'b1;
                end
                if (Z && (zcnt_q != '1)) begin
                    zcnt_q <= zcnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (PULSE_NUM != '0) begin
                            rem_q     <= PULSE_NUM;
                            gap_lat_q <= GAP;
                            err_q     <= 1'b0;
                            zcnt_q    <= '0;
                            x_q       <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= ST_PULSE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_PULSE: begin
                    rem_q   <= rem_d;
                    exp_z_q <= phase_last;
                    chk_q   <= 1'b1;
                    phase_q <= phase_last ? '0 : phase_q + PH_W'(1);
                    if (rem_d == '0) begin
                        state_q <= ST_DRAIN;
                    end else if (gap_lat_q == '0) begin
                        x_q     <= 1'b1;
                        state_q <= ST_PULSE;
                    end else begin
                        gap_cnt_q <= gap_lat_q;
                        state_q   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        x_q     <= 1'b1;
                        state_q <= ST_PULSE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_W'(1);
                    end
                end
                ST_DRAIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign X     = x_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign ERR   = err_q;
    assign Z_CNT = zcnt_q;

endmodule

// File: tb/tb_x_pulse_sequencer.sv
// Randomized bench for x_pulse_sequencer; expected per-cycle behaviour is derived
// from burst arithmetic (pulse k at cycle 1+k*(gap+1)) and a global pulse count.
module tb_x_pulse_sequencer;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;
    localparam int MOD   = 3;
    localparam int ZMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] pulse_num;
    logic [GAP_W-1:0] gap;
    logic             z;
    logic             x;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] z_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state: pulses emitted since reset, and ERR/Z_CNT as they should read now.
    int gp     = 0;
    int err_m  = 0;
    int zcnt_m = 0;

    always #5 clk = ~clk;

    x_pulse_sequencer #(.CNT_W(CNT_W), .GAP_W(GAP_W), .MOD(MOD)) dut (
        .CLK_50M   (clk),
        .RST       (rst),
        .START     (start),
        .PULSE_NUM (pulse_num),
        .GAP       (gap),
        .Z         (z),
        .X         (x),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .Z_CNT     (z_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int ex, input int eb, input int ed);
        check_val({tag, ".x"},     32'(x),     32'(ex));
        check_val({tag, ".busy"},  32'(busy),  32'(eb));
        check_val({tag, ".done"},  32'(done),  32'(ed));
        check_val({tag, ".err"},   32'(err),   32'(err_m));
        check_val({tag, ".z_cnt"}, 32'(z_cnt), 32'(zcnt_m));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            check_outs("idle", 0, 0, 0);
        end
    endtask

    // mode: 0 ideal detector, 1 Z stuck at 0, 2 ideal plus spurious Z at cycle fc,
    // 3 Z stuck at 1 while busy. rc!=0 asserts RST in cycle rc.
    task automatic run_burst(input int n, input int g, input int mode, input int fc, input int rc);
        int last;
        int ex, eb, ed, ideal, drv;
        last = 1 + (n - 1) * (g + 1);
        start     = 1'b1;
        pulse_num = CNT_W'(n);
        gap       = GAP_W'(g);
        err_m  = 0;
        zcnt_m = 0;
        for (int c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            ex = (((c - 1) % (g + 1)) == 0 && ((c - 1) / (g + 1)) < n) ? 1 : 0;
            eb = (c <= last + 1) ? 1 : 0;
            ed = (c == last + 2) ? 1 : 0;
            check_outs("burst", ex, eb, ed);
            if (c == rc) begin
                rst = 1'b1;
                #1;
                gp = 0; err_m = 0; zcnt_m = 0;
                check_outs("async_rst", 0, 0, 0);
                z = 1'b0;
                start = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                $display("burst n=%0d gap=%0d reset in cycle %0d", n, g, rc);
                return;
            end
            ideal = 0;
            if (c >= 2 && ((c - 2) % (g + 1)) == 0 && ((c - 2) / (g + 1)) < n)
                ideal = (((gp + (c - 2) / (g + 1) + 1) % MOD) == 0) ? 1 : 0;
            case (mode)
                1:       drv = 0;
                2:       drv = (ideal != 0 || c == fc) ? 1 : 0;
                3:       drv = 1;
                default: drv = ideal;
            endcase
            if (c > last + 1) drv = 0;
            z = drv[0];
            if (c <= last + 1) begin
                if (drv != ideal) err_m = 1;
                if (drv != 0 && zcnt_m < ZMAX) zcnt_m++;
            end
            // Requests while busy must be ignored; none in the DONE cycle.
            start = (c <= last + 1 && $urandom_range(7) == 0) ? 1'b1 : 1'b0;
            if (start) pulse_num = CNT_W'($urandom_range(1, 255));
        end
        gp += n;
        $display("burst n=%0d gap=%0d mode=%0d err=%0d z_cnt=%0d pulses_total=%0d",
                 n, g, mode, err_m, zcnt_m, gp);
    endtask

    task automatic zero_burst();
        start     = 1'b1;
        pulse_num = '0;
        gap       = GAP_W'($urandom_range(0, 15));
        @(negedge clk);
        start = 1'b0;
        check_outs("zero_done", 0, 0, 1);
        @(negedge clk);
        check_outs("zero_after", 0, 0, 0);
        $display("zero burst err=%0d z_cnt=%0d", err_m, zcnt_m);
    endtask

    initial begin
        int n, g, r, mode, fc, last;
        rst = 1'b1; start = 1'b0; z = 1'b0; pulse_num = '0; gap = '0;
        repeat (3) @(negedge clk);
        check_outs("reset", 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        run_burst(3, 0, 0, 0, 0);          // Z after pulse 3
        idle(2);
        run_burst(7, 2, 0, 0, 0);          // Z after pulses 3 and 6
        run_burst(2, 1, 0, 0, 0);          // accepted in DONE cycle, phase carried
        idle(1);
        run_burst(3, 0, 1, 0, 0);          // stuck-at-0 detector
        idle(3);                           // ERR held
        run_burst(4, 2, 2, 3, 0);          // spurious Z in a gap cycle
        zero_burst();
        run_burst(100, 2, 3, 0, 0);        // Z_CNT saturation

        for (int i = 0; i < 25; i++) begin
            n = $urandom_range(1, 10);
            g = $urandom_range(0, 5);
            r = $urandom_range(0, 9);
            mode = (r < 6) ? 0 : (r < 8) ? 1 : 2;
            last = 1 + (n - 1) * (g + 1);
            fc = $urandom_range(1, last + 1);
            run_burst(n, g, mode, fc, 0);
            if ($urandom_range(3) == 0) zero_burst();
            idle($urandom_range(0, 2));
        end

        run_burst(5, 3, 2, 2, 3);          // reset mid-gap after a spurious Z
        run_burst(3, 0, 0, 0, 0);          // fresh phase: Z after pulse 3
        run_burst(4, 1, 0, 0, 3);          // reset while X is high
        run_burst(3, 2, 0, 0, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
